multicycle_cpu: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle 8-bit core: same 16-bit instruction word and 8-entry register file, generalised data/PC width.
- Adds synchronous reset, a state-machine datapath, and req/ack handshaked instruction and data memory ports, so slow memories can stall the core.
- Adds HALT/illegal-opcode detection and a retire pulse for the testbench and top level.

---
 rtl/multicycle_cpu_if.sv | 27 ++
 rtl/multicycle_cpu.sv | 161 ++++++++++++++++
 tb/tb_multicycle_cpu.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_cpu_if.sv
// Instruction/data memory handshake bundle for multicycle_cpu; master = core, slave = memory.
// req is held until ack is sampled; ack is a one-cycle pulse and may arrive in the request cycle.
interface multicycle_cpu_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [15:0]       imem_rdata;
  logic              imem_ack;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, imem_ack, dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, imem_ack, dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/multicycle_cpu.sv
// Multi-cycle 16-bit-instruction core: ALU/ADDI 4 cycles, BEQ/JMP 3, SW 4, LW 5 with zero-wait memory.
// Each cycle of missing imem/dmem ack stalls the FSM in FETCH/MEM with the request held stable.
module multicycle_cpu #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  multicycle_cpu_if.master bus,
  output logic [PC_W-1:0] pc,
  output logic            retire,
  output logic            halted,
  output logic            illegal
);
  localparam int SH_W = $clog2(DATA_W);
  localparam logic [3:0] OP_R = 4'h0, OP_ADDI = 4'h1, OP_LW = 4'h2, OP_SW = 4'h3,
                         OP_BEQ = 4'h4, OP_JMP = 4'h5, OP_HALT = 4'hF;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_STOP} state_t;

  state_t            state;
  logic [15:0]       ir;
  logic [DATA_W-1:0] a, b, aluout, mdr;
  logic [DATA_W-1:0] regs [0:7];
  logic              imem_req_q, dmem_req_q, dmem_we_q;

  logic [3:0]        op;
  logic [2:0]        ra, rb, rd, func, wb_idx;
  logic [DATA_W-1:0] imm_d, alu_res, rd_a, rd_b, wb_dat;
  logic [PC_W-1:0]   pc_inc, pc_br, pc_jmp;

  assign op     = ir[15:12];
  assign ra     = ir[11:9];
  assign rb     = ir[8:6];
  assign rd     = ir[5:3];
  assign func   = ir[2:0];
  assign imm_d  = DATA_W'($signed(ir[5:0]));
  assign pc_inc = pc + PC_W'(1);
  assign pc_br  = pc_inc + PC_W'($signed(ir[5:0]));
  assign pc_jmp = pc_inc + PC_W'($signed(ir[11:0]));

  assign rd_a   = (ra == 3'd0) ? '0 : regs[ra];
  assign rd_b   = (rb == 3'd0) ? '0 : regs[rb];
  assign wb_idx = (op == OP_R) ? rd : rb;
  assign wb_dat = (op == OP_LW) ? mdr : aluout;

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = aluout;
  assign bus.dmem_wdata = b;

  // Non-R opcodes all use ra+imm6 (ADDI result or LW/SW address).
  always_comb begin
    alu_res = a + imm_d;
    if (op == OP_R) begin
      case (func)
        3'd0:    alu_res = a + b;
        3'd1:    alu_res = a - b;
        3'd2:    alu_res = a & b;
        3'd3:    alu_res = a | b;
        3'd4:    alu_res = a ^ b;
        3'd5:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
        3'd6:    alu_res = a << b[SH_W-1:0];
        default: alu_res = a >> b[SH_W-1:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      a          <= '0;
      b          <= '0;
      aluout     <= '0;
      mdr        <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      retire     <= 1'b0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_IDLE: begin
          imem_req_q <= 1'b1;
          state      <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            ir         <= bus.imem_rdata;
            imem_req_q <= 1'b0;
            state      <= S_DECODE;
          end
        end
        S_DECODE: begin
          a     <= rd_a;
          b     <= rd_b;
          state <= S_EXEC;
        end
        S_EXEC: begin
          aluout <= alu_res;
          case (op)
            OP_R, OP_ADDI: state <= S_WB;
            OP_LW, OP_SW: begin
              dmem_req_q <= 1'b1;
              dmem_we_q  <= (op == OP_SW);
              state      <= S_MEM;
            end
            OP_BEQ, OP_JMP: begin
              if (op == OP_JMP)  pc <= pc_jmp;
              else if (a == b)   pc <= pc_br;
              else               pc <= pc_inc;
              retire     <= 1'b1;
              imem_req_q <= 1'b1;
              state      <= S_FETCH;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_STOP;
            end
            default: begin
              halted  <= 1'b1;
              illegal <= 1'b1;
              state   <= S_STOP;
            end
          endcase
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (dmem_we_q) begin
              pc         <= pc_inc;
              retire     <= 1'b1;
              imem_req_q <= 1'b1;
              state      <= S_FETCH;
            end else begin
              mdr   <= bus.dmem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (wb_idx != 3'd0) regs[wb_idx] <= wb_dat;
          pc         <= pc_inc;
          retire     <= 1'b1;
          imem_req_q <= 1'b1;
          state      <= S_FETCH;
        end
        S_STOP: state <= S_STOP;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed-program bench for multicycle_cpu (DATA_W=16, PC_W=8) with latency-programmable memories.
module tb_multicycle_cpu;
  localparam int DW = 16;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_cpu_if #(.DATA_W(DW), .PC_W(PW)) bus ();
  logic [PW-1:0] pc;
  logic          retire, halted, illegal;

  multicycle_cpu #(.DATA_W(DW), .PC_W(PW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pc(pc), .retire(retire), .halted(halted), .illegal(illegal)
  );

  logic [15:0]   imem [0:255];
  logic [DW-1:0] dmem [0:255];
  int ilat = 1, dlat = 1;
  int icnt = 0, dcnt = 0;
  int st_cnt = 0;
  logic [DW-1:0] st_addr = '0, st_data = '0;

  assign bus.imem_rdata = imem[bus.imem_addr];
  assign bus.dmem_rdata = dmem[bus.dmem_addr[7:0]];
  assign bus.imem_ack   = bus.imem_req && (icnt == ilat - 1);
  assign bus.dmem_ack   = bus.dmem_req && (dcnt == dlat - 1);

  // Memory side: wait-state counters and store capture, updated like real flops.
  always @(posedge clk) begin
    icnt <= (bus.imem_req && !bus.imem_ack) ? icnt + 1 : 0;
    dcnt <= (bus.dmem_req && !bus.dmem_ack) ? dcnt + 1 : 0;
    if (bus.dmem_req && bus.dmem_we && bus.dmem_ack) begin
      st_cnt                <= st_cnt + 1;
      st_addr               <= bus.dmem_addr;
      st_data               <= bus.dmem_wdata;
      dmem[bus.dmem_addr[7:0]] <= bus.dmem_wdata;
    end
  end

  int   cyc = 0, fetch_start = 0, last_lat = 0, ret_cnt = 0;
  int   dlen = 0, last_dlen = 0, ireq_cnt = 0;
  logic prev_ireq = 1'b0;

  // Fetch-to-retire latency, retire count and dmem_req run length.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) ret_cnt = 0;
    if (retire) begin
      ret_cnt  = ret_cnt + 1;
      last_lat = cyc - fetch_start;
    end
    if (bus.imem_req && !prev_ireq) fetch_start = cyc;
    prev_ireq = bus.imem_req;
    if (bus.imem_req) ireq_cnt = ireq_cnt + 1;
    if (bus.dmem_req) dlen = dlen + 1;
    else if (dlen != 0) begin
      last_dlen = dlen;
      dlen      = 0;
    end
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [5:0] imm);
    return {op, ra, rb, imm};
  endfunction

  function automatic logic [15:0] enc_r(input logic [2:0] ra, input logic [2:0] rb,
                                        input logic [2:0] rd, input logic [2:0] fn);
    return {4'h0, ra, rb, rd, fn};
  endfunction

  task automatic start_prog(input int il, input int dl);
    rst = 1'b1;
    @(negedge clk);
    ilat = il;
    dlat = dl;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic run_to_halt(input string tag);
    for (int k = 0; k < 400 && !halted; k++) @(negedge clk);
    check(tag, halted, 1);
  endtask

  task automatic run_branch(input logic [5:0] r2v, input logic [7:0] exp_pc, input string tag);
    clear_imem();
    imem[0]  = enc_i(4'h1, 3'd0, 3'd1, 6'd7);
    imem[1]  = enc_i(4'h1, 3'd0, 3'd2, r2v);
    imem[2]  = {4'h5, 12'd7};
    imem[10] = enc_i(4'h4, 3'd1, 3'd2, 6'd2);
    start_prog(1, 1);
    run_to_halt({tag, "_halt"});
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_lat"}, last_lat, 3);
  endtask

  initial begin
    int s0, c0;
    clear_imem();
    for (int i = 0; i < 256; i++) dmem[i] = '0;

    // Reset state and the basic ALU program.
    imem[0] = enc_i(4'h1, 3'd0, 3'd1, 6'd5);
    imem[1] = enc_i(4'h1, 3'd0, 3'd2, 6'h3D);
    imem[2] = enc_r(3'd1, 3'd2, 3'd3, 3'd0);
    repeat (3) @(negedge clk);
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_dmem_req", bus.dmem_req, 0);
    check("rst_pc", pc, 0);
    check("rst_retire", retire, 0);
    check("rst_halted", halted, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_to_fetch", bus.imem_req, 1);
    run_to_halt("t1_halt");
    check("t1_r1", dut.regs[1], 16'h0005);
    check("t1_r2", dut.regs[2], 16'hFFFD);
    check("t1_r3", dut.regs[3], 16'h0002);
    check("t1_retires", ret_cnt, 3);
    check("t1_illegal", illegal, 0);
    check("t1_pc", pc, 3);
    check("t1_alu_lat", last_lat, 4);
    @(negedge clk);
    check("t1_stop_req", bus.imem_req, 0);

    // Load/store with 3-cycle data memory.
    clear_imem();
    imem[0] = enc_i(4'h1, 3'd0, 3'd1, 6'd21);
    imem[1] = enc_r(3'd1, 3'd1, 3'd1, 3'd0);
    imem[2] = enc_i(4'h3, 3'd0, 3'd1, 6'd4);
    imem[3] = enc_i(4'h2, 3'd0, 3'd4, 6'd4);
    s0 = st_cnt;
    start_prog(1, 3);
    run_to_halt("t2_halt");
    check("t2_stores", st_cnt - s0, 1);
    check("t2_st_addr", st_addr, 16'h0004);
    check("t2_st_data", st_data, 16'h002A);
    check("t2_dreq_len", last_dlen, 3);
    check("t2_r4", dut.regs[4], 16'h002A);
    check("t2_lw_lat", last_lat, 7);
    check("t2_retires", ret_cnt, 4);

    // Branch taken / not taken, then a self-jump.
    run_branch(6'd7, 8'd13, "t3_taken");
    run_branch(6'd6, 8'd11, "t3_nottaken");
    clear_imem();
    imem[0] = {4'h5, 12'hFFF};
    start_prog(1, 1);
    for (int k = 0; k < 100 && ret_cnt < 2; k++) @(negedge clk);
    check("t3_jmp_retires", ret_cnt >= 2, 1);
    check("t3_jmp_pc", pc, 0);
    check("t3_jmp_halted", halted, 0);

    // 16-bit ALU edges with a 2-cycle instruction memory.
    clear_imem();
    imem[0] = enc_i(4'h1, 3'd0, 3'd1, 6'h3F);
    imem[1] = enc_i(4'h1, 3'd0, 3'd2, 6'd1);
    imem[2] = enc_r(3'd1, 3'd2, 3'd3, 3'd7);
    imem[3] = enc_r(3'd3, 3'd2, 3'd4, 3'd0);
    imem[4] = enc_r(3'd4, 3'd2, 3'd5, 3'd5);
    imem[5] = enc_i(4'h1, 3'd0, 3'd6, 6'd17);
    imem[6] = enc_r(3'd2, 3'd6, 3'd7, 3'd6);
    imem[7] = enc_i(4'h1, 3'd2, 3'd0, 6'd5);
    imem[8] = enc_r(3'd0, 3'd2, 3'd6, 3'd0);
    start_prog(2, 1);
    run_to_halt("t4_halt");
    check("t4_shr", dut.regs[3], 16'h7FFF);
    check("t4_add_wrap", dut.regs[4], 16'h8000);
    check("t4_slt", dut.regs[5], 16'h0001);
    check("t4_shl17", dut.regs[7], 16'h0002);
    check("t4_r0", dut.regs[6], 16'h0001);
    check("t4_lat_wait", last_lat, 5);
    check("t4_pc", pc, 9);

    // Illegal opcode at pc=5.
    clear_imem();
    imem[0] = {4'h5, 12'd4};
    imem[5] = 16'h9000;
    start_prog(1, 1);
    run_to_halt("t5_halt");
    check("t5_illegal", illegal, 1);
    check("t5_pc", pc, 5);
    c0 = ireq_cnt;
    repeat (10) @(negedge clk);
    check("t5_no_fetch", ireq_cnt - c0, 0);
    check("t5_pc_frozen", pc, 5);
    check("t5_retires", ret_cnt, 1);

    // Reset landing on the LW ack edge.
    clear_imem();
    imem[0] = enc_i(4'h1, 3'd0, 3'd1, 6'd9);
    imem[1] = enc_i(4'h3, 3'd0, 3'd1, 6'd3);
    imem[2] = enc_i(4'h2, 3'd0, 3'd4, 6'd3);
    start_prog(1, 3);
    for (int k = 0; k < 100 && !(bus.dmem_req && !bus.dmem_we); k++) @(negedge clk);
    check("t6_lw_req", bus.dmem_req && !bus.dmem_we, 1);
    for (int k = 0; k < 10 && !bus.dmem_ack; k++) @(negedge clk);
    check("t6_ack_seen", bus.dmem_ack, 1);
    s0 = st_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("t6_imem_req", bus.imem_req, 0);
    check("t6_dmem_req", bus.dmem_req, 0);
    check("t6_dmem_we", bus.dmem_we, 0);
    check("t6_pc", pc, 0);
    check("t6_retire", retire, 0);
    check("t6_halted", halted, 0);
    check("t6_r4", dut.regs[4], 0);
    check("t6_no_store", st_cnt - s0, 0);
    rst = 1'b0;
    check("t6_idle_req", bus.imem_req, 0);
    @(negedge clk);
    check("t6_refetch", bus.imem_req, 1);
    check("t6_refetch_addr", bus.imem_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
